// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder and anything that drives its segment pins.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package seg7_pkg;

    localparam int DIGITS_DEFAULT        = 8;
    localparam int STABLE_CYCLES_DEFAULT = 4;

    // Segment order is {a,b,c,d,e,f,g}, with a in bit 6.
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    localparam logic [6:0] SEG_CODES [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

    typedef struct packed {
        logic [3:0] nibble;
        logic       invalid;
    } hex_dec_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_CODES[nibble];
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup from a 7-segment pattern to its hex nibble, flagging non-hex patterns.
// Latency: purely combinational.
// Backpressure: none.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_CODES[i]) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the hex digits shown on a multiplexed 7-segment display by sniffing its select/segment pins.
// Latency: a stable pin pattern lands in the outputs on the (STABLE_CYCLES+2)-th clock edge after it appears.
// Backpressure: none; pins are sampled every cycle and the block never stalls.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = DIGITS_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     num_csn,
    input  logic [6:0]            num_a_g,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     seg_err,
    output logic                  frame_done,
    output logic                  csn_err
);

    typedef struct packed {
        logic [DIGITS-1:0] csn;
        logic [6:0]        seg;
    } pins_t;

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

    pins_t             sync1;
    pins_t             sync2;
    pins_t             prev;
    logic [3:0]        stable_cnt;
    logic [DIGITS-1:0] seen;

    logic              sample_changed;
    logic [3:0]        cnt_next;
    logic              evaluate;
    logic [DIGITS-1:0] sel_low;
    logic              sel_onehot;
    logic              capture;
    logic [DIGITS-1:0] seen_base;
    hex_dec_t          dec;

    seg7_to_hex u_seg7_to_hex (
        .pattern (sync2.seg),
        .nibble  (dec.nibble),
        .invalid (dec.invalid)
    );

    always_comb begin
        sample_changed = (sync2 != prev);
        if (sample_changed) begin
            cnt_next = 4'd1;
        end else if (stable_cnt == STABLE_MAX) begin
            cnt_next = stable_cnt;
        end else begin
            cnt_next = stable_cnt + 4'd1;
        end
        // Only the edge that reaches the threshold evaluates; saturation keeps a held display silent.
        evaluate   = (cnt_next == STABLE_MAX) && (stable_cnt != STABLE_MAX);
        sel_low    = ~sync2.csn;
        sel_onehot = (sel_low != '0) && ((sel_low & (sel_low - DIGITS'(1))) == '0);
        capture    = evaluate && sel_onehot;
        // A full frame is retired on the same edge it is reported, so a coincident capture starts the next one.
        seen_base  = (&seen) ? '0 : seen;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            stable_cnt  <= '0;
            seen        <= '0;
            digits      <= '0;
            digit_valid <= '0;
            seg_err     <= '0;
            frame_done  <= 1'b0;
            csn_err     <= 1'b0;
        end else begin
            sync1      <= pins_t'{csn: num_csn, seg: num_a_g};
            sync2      <= sync1;
            prev       <= sync2;
            stable_cnt <= cnt_next;
            frame_done <= &seen;
            csn_err    <= evaluate && !sel_onehot;
            seen       <= capture ? (seen_base | sel_low) : seen_base;
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && sel_low[i]) begin
                    digits[4*i +: 4] <= dec.nibble;
                    digit_valid[i]   <= 1'b1;
                    seg_err[i]       <= dec.invalid;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized scanning against a history-window model.
// Latency: n/a. Backpressure: n/a.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 8;
    localparam int STABLE = 4;
    localparam int HW     = DIGITS + 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [DIGITS-1:0]   num_csn;
    logic [6:0]          num_a_g;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   digit_valid;
    logic [DIGITS-1:0]   seg_err;
    logic                frame_done;
    logic                csn_err;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .num_csn     (num_csn),
        .num_a_g     (num_a_g),
        .digits      (digits),
        .digit_valid (digit_valid),
        .seg_err     (seg_err),
        .frame_done  (frame_done),
        .csn_err     (csn_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;
    int ce_count = 0;

    // Model state: raw pin history (one entry per clock edge) plus the expected outputs.
    logic [HW-1:0]       hist [$];
    logic [4*DIGITS-1:0] m_digits;
    logic [DIGITS-1:0]   m_valid;
    logic [DIGITS-1:0]   m_err;
    logic [DIGITS-1:0]   m_seen;
    logic                m_fd;
    logic                m_ce;

    function automatic logic [6:0] spec_code(input int v);
        case (v)
            0:  return 7'h7E;
            1:  return 7'h30;
            2:  return 7'h6D;
            3:  return 7'h79;
            4:  return 7'h33;
            5:  return 7'h5B;
            6:  return 7'h5F;
            7:  return 7'h70;
            8:  return 7'h7F;
            9:  return 7'h7B;
            10: return 7'h77;
            11: return 7'h1F;
            12: return 7'h4E;
            13: return 7'h3D;
            14: return 7'h4F;
            15: return 7'h47;
            default: return 7'h00;
        endcase
    endfunction

    // Bit 4 set means the pattern is not a hex glyph.
    function automatic logic [4:0] spec_decode(input logic [6:0] p);
        for (int v = 0; v < 16; v++) begin
            if (spec_code(v) == p) return {1'b0, 4'(v)};
        end
        return 5'h10;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        // Sentinel entry marks the start of the post-reset run; the reset zeros then follow.
        hist.push_back({1'b1, {(HW-1){1'b0}}});
        hist.push_back('0);
        hist.push_back('0);
        m_digits = '0;
        m_valid  = '0;
        m_err    = '0;
        m_seen   = '0;
        m_fd     = 1'b0;
        m_ce     = 1'b0;
    endtask

    task automatic model_step();
        int                j;
        bit                eval;
        int                lows;
        int                idx;
        logic [DIGITS-1:0] c;
        logic [4:0]        d;
        hist.push_back({1'b0, num_csn, num_a_g});
        if (hist.size() > 32) void'(hist.pop_front());
        // The sample examined at this edge is the one that arrived two edges ago.
        j    = hist.size() - 3;
        eval = 1'b0;
        if (j >= STABLE) begin
            eval = 1'b1;
            for (int k = 1; k < STABLE; k++) begin
                if (hist[j-k] !== hist[j]) eval = 1'b0;
            end
            if (hist[j-STABLE] === hist[j]) eval = 1'b0;
        end
        m_fd = &m_seen;
        if (m_fd) m_seen = '0;
        m_ce = 1'b0;
        if (eval) begin
            c    = hist[j][HW-2:7];
            lows = 0;
            idx  = 0;
            for (int i = 0; i < DIGITS; i++) begin
                if (!c[i]) begin
                    lows++;
                    idx = i;
                end
            end
            if (lows == 1) begin
                d                    = spec_decode(hist[j][6:0]);
                m_digits[4*idx +: 4] = d[3:0];
                m_valid[idx]         = 1'b1;
                m_err[idx]           = d[4];
                m_seen[idx]          = 1'b1;
            end else begin
                m_ce = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
        #1;
        check("digits",      64'(digits),      64'(m_digits));
        check("digit_valid", 64'(digit_valid), 64'(m_valid));
        check("seg_err",     64'(seg_err),     64'(m_err));
        check("frame_done",  64'(frame_done),  64'(m_fd));
        check("csn_err",     64'(csn_err),     64'(m_ce));
        if (frame_done) fd_count++;
        if (csn_err)    ce_count++;
    end

    task automatic hold(input logic [DIGITS-1:0] c, input logic [6:0] s, input int n);
        num_csn = c;
        num_a_g = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input int count);
        for (int i = 0; i < count; i++) begin
            hold(~(DIGITS'(1) << i), spec_code(i + 1), 8);
        end
    endtask

    initial begin
        reset   = 1'b1;
        num_csn = '1;
        num_a_g = '0;
        repeat (3) @(negedge clk);
        check("reset_digits", 64'(digits), 64'h0);
        check("reset_valid",  64'(digit_valid), 64'h0);
        reset = 1'b0;
        hold('1, 7'h00, 10);

        // Single capture lands on the sixth edge, not the fifth.
        num_csn = 8'hFE;
        num_a_g = 7'h30;
        repeat (5) @(negedge clk);
        check("single_before_edge6", 64'(digit_valid), 64'h00);
        @(negedge clk);
        check("single_valid", 64'(digit_valid), 64'h01);
        check("single_nibble", 64'(digits[3:0]), 64'h1);
        check("single_seg_err", 64'(seg_err), 64'h00);
        repeat (4) @(negedge clk);

        // A run shorter than the threshold is rejected.
        hold(8'hFD, 7'h6D, 3);
        hold('1, 7'h00, 10);
        check("glitch_valid", 64'(digit_valid), 64'h01);

        // Two selects low: one csn_err pulse, no digit change.
        ce_count = 0;
        hold(8'hFC, 7'h4E, 8);
        check("csn_err_once", 64'(ce_count), 64'd1);
        check("csn_err_valid", 64'(digit_valid), 64'h01);

        // Non-hex pattern on digit 2.
        hold(8'hFB, 7'h01, 8);
        check("bad_seg_err2", 64'(seg_err[2]), 64'h1);
        check("bad_seg_nibble", 64'(digits[11:8]), 64'h0);
        check("bad_seg_valid", 64'(digit_valid), 64'h05);

        // Full frame: one frame_done, digit 2 rewritten clears its error.
        fd_count = 0;
        scan(DIGITS);
        hold('1, 7'h00, 10);
        check("frame_count", 64'(fd_count), 64'd1);
        check("frame_digits", 64'(digits), 64'h87654321);
        check("frame_model_digits", 64'(m_digits), 64'h87654321);
        check("frame_seg_err", 64'(seg_err), 64'h00);

        // Mid-frame reset discards the partial frame.
        scan(5);
        reset = 1'b1;
        #1;
        check("midreset_digits", 64'(digits), 64'h0);
        check("midreset_valid", 64'(digit_valid), 64'h0);
        check("midreset_seg_err", 64'(seg_err), 64'h0);
        check("midreset_pulses", 64'({frame_done, csn_err}), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold('1, 7'h00, 10);
        fd_count = 0;
        scan(DIGITS);
        hold('1, 7'h00, 10);
        check("rescan_frame_count", 64'(fd_count), 64'd1);
        check("rescan_digits", 64'(digits), 64'h87654321);

        // Randomized scanning with occasional garbage, short glitches and resets.
        for (int it = 0; it < 400; it++) begin
            logic [DIGITS-1:0] c;
            logic [6:0]        s;
            int                r;
            r = $urandom_range(0, 9);
            if (r == 0)      c = '1;
            else if (r == 1) c = DIGITS'($urandom);
            else             c = ~(DIGITS'(1) << $urandom_range(0, DIGITS - 1));
            if ($urandom_range(0, 4) == 0) s = 7'($urandom);
            else                           s = spec_code(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
            end
            hold(c, s, int'($urandom_range(1, 9)));
        end
        hold('1, 7'h00, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
